pc_controller: RTL and testbench

PC_CONTROLLER -- requirements
Module: pc_controller

---
 rtl/pc_ctrl_pkg.sv | 13 +
 rtl/pc_controller_if.sv | 11 +
 rtl/pc_reg.sv | 22 ++
 rtl/pc_controller.sv | 113 +++++++++++
 tb/tb_pc_controller.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/pc_ctrl_pkg.sv
// rtl/pc_ctrl_pkg.sv - shared types and constants for the fetch PC controller
package pc_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } pc_state_t;

   localparam int unsigned PC_INC            = 4;
   localparam int unsigned DEFAULT_RESET_VEC = 0;

endpackage

// File: rtl/pc_controller_if.sv
// rtl/pc_controller_if.sv - instruction memory request/ack bus between PC controller and imem
interface pc_controller_if #(
   parameter int unsigned Width = 32
);
   logic             imem_req;
   logic [Width-1:0] imem_addr;
   logic             imem_ack;

   modport master (output imem_req, output imem_addr, input imem_ack);
   modport slave  (input imem_req, input imem_addr, output imem_ack);
endinterface

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - enable-gated PC register with asynchronous active-low reset
module pc_reg #(
   parameter int unsigned      Width     = 32,
   parameter logic [Width-1:0] RESET_VEC = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [Width-1:0] d,
   output logic [Width-1:0] q
);

   // PC storage: load on enable, RESET_VEC on reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q <= RESET_VEC;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/pc_controller.sv
// rtl/pc_controller.sv - fetch PC controller with redirect/drain FSM; optional macro PC_MISALIGN_TRAP_EN
module pc_controller
   import pc_ctrl_pkg::*;
#(
   parameter int unsigned      Width     = 32,
   parameter logic [Width-1:0] RESET_VEC = Width'(DEFAULT_RESET_VEC)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             br_taken,
   input  logic [Width-1:0] br_target,
   input  logic             trap_req,
   input  logic [Width-1:0] trap_vec,
   pc_controller_if.master  imem,
   output logic             instr_valid,
   output logic             flush,
`ifdef PC_MISALIGN_TRAP_EN
   output logic             misalign_exc,
`endif
   output logic [Width-1:0] pc_cur
);

   pc_state_t        state_q;
   pc_state_t        state_d;
   logic             redirect;
   logic             pc_en;
   logic [Width-1:0] sel_target;
   logic [Width-1:0] target;
   logic [Width-1:0] pc_d;

   // Trap wins over branch; a misaligned branch target becomes a trap when enabled
`ifdef PC_MISALIGN_TRAP_EN
   logic misaligned;
   assign misaligned   = br_taken && !trap_req && (br_target[1:0] != 2'b00);
   assign sel_target   = (trap_req || misaligned) ? trap_vec : br_target;
   assign misalign_exc = misaligned && (state_q != IDLE);
`else
   assign sel_target   = trap_req ? trap_vec : br_target;
`endif

   // Every fetch address is word aligned
   assign target   = sel_target & ~Width'(3);
   // The single IDLE cycle after reset does not take redirects
   assign redirect = (trap_req || br_taken) && (state_q != IDLE);

   assign imem.imem_addr = pc_cur;

   pc_reg #(
      .Width     (Width),
      .RESET_VEC (RESET_VEC)
   ) u_pc_reg (
      .clk   (clk),
      .reset (reset),
      .en    (pc_en),
      .d     (pc_d),
      .q     (pc_cur)
   );

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state, next PC and handshake outputs
   always_comb begin
      state_d       = state_q;
      imem.imem_req = 1'b0;
      instr_valid   = 1'b0;
      flush         = 1'b0;
      pc_en         = 1'b0;
      pc_d          = pc_cur;
      case (state_q)
         IDLE: begin
            state_d = FETCH;
         end
         FETCH: begin
            imem.imem_req = !stall;
            flush         = redirect;
            if (redirect) begin
               pc_en = 1'b1;
               pc_d  = target;
               // An outstanding request must have its late ack swallowed
               if (!stall && !imem.imem_ack) begin
                  state_d = DRAIN;
               end
            end else if (!stall && imem.imem_ack) begin
               instr_valid = 1'b1;
               pc_en       = 1'b1;
               pc_d        = pc_cur + Width'(PC_INC);
            end
         end
         DRAIN: begin
            flush = redirect;
            if (redirect) begin
               pc_en = 1'b1;
               pc_d  = target;
            end
            if (imem.imem_ack) begin
               state_d = FETCH;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_pc_controller.sv
// tb/tb_pc_controller.sv - self-checking bench for pc_controller against a cycle model
module tb_pc_controller;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        br_taken;
   logic [31:0] br_target;
   logic        trap_req;
   logic [31:0] trap_vec;
   logic        instr_valid;
   logic        flush;
   logic [31:0] pc_cur;
`ifdef PC_MISALIGN_TRAP_EN
   logic        misalign_exc;
   localparam bit MIS_EN = 1'b1;
`else
   localparam bit MIS_EN = 1'b0;
`endif

   int n_cmp;
   int n_bad;

   pc_controller_if #(.Width(32)) imem_bus ();

   pc_controller #(
      .Width     (32),
      .RESET_VEC (32'h0)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .br_taken    (br_taken),
      .br_target   (br_target),
      .trap_req    (trap_req),
      .trap_vec    (trap_vec),
      .imem        (imem_bus),
      .instr_valid (instr_valid),
      .flush       (flush),
`ifdef PC_MISALIGN_TRAP_EN
      .misalign_exc(misalign_exc),
`endif
      .pc_cur      (pc_cur)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the PC, whether the first post-reset cycle has passed, and whether a stale ack is owed
   logic [31:0] m_pc;
   bit          m_started;
   bit          m_drain;
   bit          e_req, e_valid, e_flush, e_mis, redir, mis;
   logic [31:0] tgt;

   always @(negedge clk) begin
      if (!reset) begin
         m_pc = 32'h0; m_started = 1'b0; m_drain = 1'b0;
         chk("rst_req", {31'b0, imem_bus.imem_req}, 32'd0);
         chk("rst_valid", {31'b0, instr_valid}, 32'd0);
         chk("rst_flush", {31'b0, flush}, 32'd0);
         chk("rst_pc", pc_cur, 32'h0);
      end else begin
         mis   = MIS_EN && br_taken && !trap_req && (br_target[1:0] != 2'b00);
         tgt   = (trap_req || mis) ? trap_vec : br_target;
         tgt[1:0] = 2'b00;
         redir   = m_started && (trap_req || br_taken);
         e_req   = m_started && !m_drain && !stall;
         e_valid = e_req && imem_bus.imem_ack && !redir;
         e_flush = redir;
         e_mis   = m_started && mis;
         chk("req", {31'b0, imem_bus.imem_req}, {31'b0, e_req});
         chk("addr", imem_bus.imem_addr, m_pc);
         chk("pc", pc_cur, m_pc);
         chk("valid", {31'b0, instr_valid}, {31'b0, e_valid});
         chk("flush", {31'b0, flush}, {31'b0, e_flush});
`ifdef PC_MISALIGN_TRAP_EN
         chk("mis", {31'b0, misalign_exc}, {31'b0, e_mis});
`endif
         if (!m_started) begin
            m_started = 1'b1;
         end else if (redir) begin
            if (e_req && !imem_bus.imem_ack) m_drain = 1'b1;
            else if (m_drain && imem_bus.imem_ack) m_drain = 1'b0;
            m_pc = tgt;
         end else if (m_drain) begin
            if (imem_bus.imem_ack) m_drain = 1'b0;
         end else if (e_valid) begin
            m_pc = m_pc + 32'd4;
         end
      end
   end

   task automatic cyc(input bit s, input bit b, input logic [31:0] bt,
                      input bit t, input logic [31:0] tv, input bit a);
      @(posedge clk);
      #1;
      stall = s; br_taken = b; br_target = bt; trap_req = t; trap_vec = tv;
      imem_bus.imem_ack = a;
      #1;
   endtask

   initial begin
      n_cmp = 0; n_bad = 0;
      reset = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = '0;
      trap_req = 1'b0; trap_vec = '0; imem_bus.imem_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("p_rst_pc", pc_cur, 32'h0);
      chk("p_rst_req", {31'b0, imem_bus.imem_req}, 32'd0);
      // release; first cycle is IDLE and ignores ack
      reset = 1'b1; imem_bus.imem_ack = 1'b1;
      #1;
      chk("p_idle_req", {31'b0, imem_bus.imem_req}, 32'd0);
      chk("p_idle_valid", {31'b0, instr_valid}, 32'd0);
      // sequential fetch 0,4,8
      cyc(0, 0, 0, 0, 0, 1);
      chk("p_a0", imem_bus.imem_addr, 32'h0); chk("p_v0", {31'b0, instr_valid}, 32'd1);
      cyc(0, 0, 0, 0, 0, 1);
      chk("p_a4", imem_bus.imem_addr, 32'h4); chk("p_v4", {31'b0, instr_valid}, 32'd1);
      cyc(0, 0, 0, 0, 0, 1);
      chk("p_a8", imem_bus.imem_addr, 32'h8); chk("p_v8", {31'b0, instr_valid}, 32'd1);
      // branch coinciding with ack
      cyc(0, 1, 32'h100, 0, 0, 1);
      chk("p_br_valid", {31'b0, instr_valid}, 32'd0); chk("p_br_flush", {31'b0, flush}, 32'd1);
      cyc(0, 0, 0, 0, 0, 0);
      chk("p_br_addr", imem_bus.imem_addr, 32'h100); chk("p_br_flush0", {31'b0, flush}, 32'd0);
      // trap while request outstanding -> drain
      cyc(0, 0, 0, 1, 32'h80, 0);
      chk("p_tr_flush", {31'b0, flush}, 32'd1);
      cyc(0, 0, 0, 0, 0, 0);
      chk("p_dr_req", {31'b0, imem_bus.imem_req}, 32'd0); chk("p_dr_pc", pc_cur, 32'h80);
      cyc(0, 0, 0, 0, 0, 1);
      chk("p_dr_drop", {31'b0, instr_valid}, 32'd0);
      cyc(0, 0, 0, 0, 0, 1);
      chk("p_dr_addr", imem_bus.imem_addr, 32'h80); chk("p_dr_valid", {31'b0, instr_valid}, 32'd1);
      // trap beats branch
      cyc(0, 1, 32'h200, 1, 32'h80, 1);
      chk("p_prio_addr", imem_bus.imem_addr, 32'h84);
      cyc(0, 0, 0, 0, 0, 0);
      chk("p_prio_pc", pc_cur, 32'h80);
      cyc(0, 1, 32'h10, 0, 0, 1);
      // stall holds PC; redirect accepted under stall
      for (int i = 0; i < 3; i++) begin
         cyc(1, 0, 0, 0, 0, 0);
         chk("p_st_req", {31'b0, imem_bus.imem_req}, 32'd0); chk("p_st_pc", pc_cur, 32'h10);
      end
      cyc(1, 1, 32'h40, 0, 0, 0);
      chk("p_st_flush", {31'b0, flush}, 32'd1);
      cyc(1, 0, 0, 0, 0, 0);
      chk("p_st_pc40", pc_cur, 32'h40);
      cyc(0, 0, 0, 0, 0, 1);
      chk("p_st_addr40", imem_bus.imem_addr, 32'h40);
      // wrap at top of address space
      cyc(0, 1, 32'hFFFF_FFFC, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 1);
      chk("p_wr_addr", imem_bus.imem_addr, 32'hFFFF_FFFC); chk("p_wr_valid", {31'b0, instr_valid}, 32'd1);
      cyc(0, 0, 0, 0, 0, 0);
      chk("p_wr_pc", pc_cur, 32'h0);
      // misaligned branch target, outstanding request -> drain
      cyc(0, 1, 32'h102, 0, 32'h300, 0);
      chk("p_mis_flush", {31'b0, flush}, 32'd1);
`ifdef PC_MISALIGN_TRAP_EN
      chk("p_mis_exc", {31'b0, misalign_exc}, 32'd1);
`endif
      cyc(0, 0, 0, 0, 0, 0);
      chk("p_mis_pc", pc_cur, MIS_EN ? 32'h300 : 32'h100);
      // redirect during drain stays in drain
      cyc(0, 1, 32'h20, 0, 0, 0);
      chk("p_dd_flush", {31'b0, flush}, 32'd1);
      cyc(0, 0, 0, 0, 0, 0);
      chk("p_dd_pc", pc_cur, 32'h20); chk("p_dd_req", {31'b0, imem_bus.imem_req}, 32'd0);
      cyc(0, 0, 0, 0, 0, 1);
      chk("p_dd_drop", {31'b0, instr_valid}, 32'd0);
      cyc(0, 0, 0, 0, 0, 1);
      chk("p_dd_addr", imem_bus.imem_addr, 32'h20); chk("p_dd_valid", {31'b0, instr_valid}, 32'd1);
      cyc(0, 0, 0, 0, 0, 0);
      chk("p_out_addr", imem_bus.imem_addr, 32'h24);
      // asynchronous reset mid-request
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      chk("p_ar_pc", pc_cur, 32'h0); chk("p_ar_req", {31'b0, imem_bus.imem_req}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1; imem_bus.imem_ack = 1'b1;
      #1;
      chk("p_ar_idle", {31'b0, imem_bus.imem_req}, 32'd0);
      cyc(0, 0, 0, 0, 0, 1);
      chk("p_ar_addr", imem_bus.imem_addr, 32'h0); chk("p_ar_valid", {31'b0, instr_valid}, 32'd1);
      cyc(0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
